mem_axi_window: RTL and testbench
=================================

Name: mem_axi_window

Overview:
- AXI4 window/remap stage between Rocket's memory master port (io_mem_axi_*) and the PS HP slave port (S_AXI_*).
- Checks each AR/AW burst against the Rocket memory window and relocates legal bursts into the DRAM region reserved for Rocket (upper 256 MB of 512 MB).
- Answers illegal bursts locally with DECERR so stray accesses never reach PS DRAM.
- Legal traffic passes with zero added latency.

Parameters:
- ADDR_W, 32, address width on both sides
- DATA_W, 64, data width; STRB_W = DATA_W/8
- ID_W, 6, AXI ID width
- WIN_BITS, 28, log2 of window size (256 MB)
- SRC_TAG, 4'h8, required value of s addr[ADDR_W-1:WIN_BITS]
- DST_TAG, 4'h1, value substituted into m addr[ADDR_W-1:WIN_BITS]
- MAX_OUT, 8, maximum outstanding legal reads, and separately maximum outstanding legal writes

Ports:
- clock  in  1  sole clock (host_clk domain)
- reset_n  in  1  asynchronous, active-low reset
- s_ar_*  in/out  AXI4 AR channel from Rocket: valid, ready, addr[ADDR_W], id[ID_W], len[8], size[3], burst[2], lock, cache[4], prot[3], qos[4]
- s_aw_*  in/out  AXI4 AW channel from Rocket, same field set as s_ar_*
- s_w_*  in/out  valid, ready, data[DATA_W], strb[STRB_W], last
- s_b_*  out/in  valid, ready, id[ID_W], resp[2]
- s_r_*  out/in  valid, ready, id[ID_W], data[DATA_W], resp[2], last
- m_ar_*, m_aw_*, m_w_*, m_b_*, m_r_*  mirror of the s_* channels toward the PS slave port, directions reversed
- err_count  out  16  saturating count of DECERR bursts issued

Behaviour:
- Reset: all valids/readies low, counters 0, both FSMs IDLE, err_count 0.
- Legality: tag == SRC_TAG AND burst stays inside the window. Window check: addr[WIN_BITS-1:0] + ((len+1) << size) <= 2^WIN_BITS, computed at WIN_BITS+1 bits. burst==FIXED uses a span of 1<<size. burst==WRAP is always legal when the tag matches.
- Legal AR/AW: combinational pass-through. m addr = {DST_TAG, addr[WIN_BITS-1:0]}; all other fields unchanged.
- rd_out: +1 on each m_ar handshake, −1 on m_r handshake with last.
- wr_out: +1 on each m_aw handshake, −1 on m_b handshake.
- When a counter equals MAX_OUT, the matching legal AR/AW is stalled (s ready low).
- w_pend counts legal AWs whose last W beat has not been forwarded.
- W forwarding: s_w routes to m_w only while w_pend > 0; otherwise s_w_ready is low, except in W_DRAIN.
- Simultaneous legal AW and W-last handshake: w_pend is unchanged.
- Read error FSM:
  - IDLE: illegal AR → accept it (s_ar_ready=1 for one cycle), capture id and len, go R_WAIT.
  - R_WAIT: when rd_out==0 → R_RESP.
  - R_RESP: drive s_r with data 0, resp 2'b11, captured id; last asserted on beat len. After len+1 handshakes → IDLE.
  - No AR is accepted outside IDLE.
  - m_r owns s_r whenever the FSM is not in R_RESP. This is guaranteed because rd_out==0 before R_RESP is entered.
- Write error FSM:
  - IDLE: illegal AW → accept it, capture id, go W_WAIT. No AW is accepted outside IDLE.
  - W_WAIT: legal W beats keep flowing. When w_pend==0 and wr_out==0 → W_DRAIN.
  - W_DRAIN: s_w_ready=1; beats are discarded, m_w_valid=0. On the handshake with last → W_RESP.
  - W_RESP: s_b_valid=1, resp 2'b11, captured id. On handshake → IDLE and err_count++.
- Read DECERR also increments err_count on final beat handshake. err_count saturates at 16'hFFFF.
- Response ordering: DECERR is never interleaved with, or reordered ahead of, an earlier legal response.
- Reset mid-burst: every FSM and counter returns to reset value at once; no partial beat is held.

Decomposition:
- Package mem_axi_pkg:
  - AXI_RESP_OKAY / AXI_RESP_DECERR constants
  - burst encodings FIXED/INCR/WRAP
  - width localparams
  - ax_t struct (addr, id, len, size, burst, lock, cache, prot, qos)
- Sub-module mem_axi_win_check: combinational legality check plus address remap. It is instantiated once for AR and once for AW.
- FSMs and counters stay in the top module.

Test Plan:
- Legal INCR read, addr 0x8000_1000, len 7, size 3 → m_ar addr 0x1000_1000, len 7; 8 R beats returned unmodified, zero added latency.
- Illegal read, addr 0x4000_0000, len 3, id 5 → no m_ar; 4 beats resp 2'b11, data 0, id 5, last on beat 4; err_count=1.
- Crossing write, addr 0x8FFF_FFC0, len 15, size 3 (span 128 B) → no m_aw; 16 W beats dropped; one B with DECERR.
- Legal write (len 3) outstanding, then illegal AW issued before its B → DECERR B only after legal B; legal W beats reach m_w unaltered.
- MAX_OUT=8 legal reads outstanding with m_r held off → 9th AR sees s_ar_ready=0 until the first final beat completes.
- reset_n asserted during R_RESP at beat 2 of 4 → s_r_valid=0 and FSM in IDLE next cycle; a fresh legal AR after release passes normally.

Source files
------------

// File: rtl/mem_axi_pkg.sv
// Shared AXI4 encodings, window constants and the address-channel bundle.
// Address-window constants describe where Rocket's memory sits in PS DRAM.
package mem_axi_pkg;

    localparam int ADDR_W   = 32;
    localparam int DATA_W   = 64;
    localparam int STRB_W   = DATA_W / 8;
    localparam int ID_W     = 6;
    localparam int WIN_BITS = 28;
    localparam int TAG_W    = ADDR_W - WIN_BITS;
    localparam int MAX_OUT  = 8;
    localparam int CNT_W    = $clog2(MAX_OUT + 1);

    localparam logic [TAG_W-1:0] SRC_TAG = 4'h8;
    localparam logic [TAG_W-1:0] DST_TAG = 4'h1;

    localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
    localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] BURST_WRAP  = 2'b10;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [ID_W-1:0]   id;
        logic [7:0]        len;
        logic [2:0]        size;
        logic [1:0]        burst;
        logic              lock;
        logic [3:0]        cache;
        logic [2:0]        prot;
        logic [3:0]        qos;
    } ax_t;

    typedef enum logic [1:0] {R_IDLE, R_WAIT, R_RESP} rd_state_t;
    typedef enum logic [1:0] {W_IDLE, W_WAIT, W_DRAIN, W_RESP} wr_state_t;

endpackage

// File: rtl/mem_axi_win_check.sv
// Window legality check and tag relocation for one AR or AW request.
// Purely combinational; no backpressure of its own.
module mem_axi_win_check
    import mem_axi_pkg::*;
(
    input  ax_t  s_ax,
    output logic legal,
    output ax_t  m_ax
);

    typedef logic [WIN_BITS:0] ofs_t;
    localparam ofs_t WIN_SIZE = ofs_t'(1) << WIN_BITS;

    ofs_t span;
    ofs_t end_ofs;
    logic tag_ok;

    always_comb begin
        // FIXED bursts hit one beat's worth of bytes repeatedly.
        if (s_ax.burst == BURST_FIXED) begin
            span = ofs_t'(1) << s_ax.size;
        end else begin
            span = (ofs_t'(s_ax.len) + ofs_t'(1)) << s_ax.size;
        end
        end_ofs = ofs_t'(s_ax.addr[WIN_BITS-1:0]) + span;
        tag_ok  = s_ax.addr[ADDR_W-1:WIN_BITS] == SRC_TAG;
        legal   = tag_ok && ((s_ax.burst == BURST_WRAP) || (end_ofs <= WIN_SIZE));

        m_ax      = s_ax;
        m_ax.addr = {DST_TAG, s_ax.addr[WIN_BITS-1:0]};
    end

endmodule

// File: rtl/mem_axi_window.sv
// Rocket-to-PS AXI4 window: relocates legal bursts, answers stray ones with DECERR.
// Legal traffic is zero-latency pass-through; readies follow the PS side, error bursts wait for older traffic.
module mem_axi_window
    import mem_axi_pkg::*;
(
    input  logic              clock,
    input  logic              reset_n,

    input  logic              s_ar_valid,
    output logic              s_ar_ready,
    input  logic [ADDR_W-1:0] s_ar_addr,
    input  logic [ID_W-1:0]   s_ar_id,
    input  logic [7:0]        s_ar_len,
    input  logic [2:0]        s_ar_size,
    input  logic [1:0]        s_ar_burst,
    input  logic              s_ar_lock,
    input  logic [3:0]        s_ar_cache,
    input  logic [2:0]        s_ar_prot,
    input  logic [3:0]        s_ar_qos,

    input  logic              s_aw_valid,
    output logic              s_aw_ready,
    input  logic [ADDR_W-1:0] s_aw_addr,
    input  logic [ID_W-1:0]   s_aw_id,
    input  logic [7:0]        s_aw_len,
    input  logic [2:0]        s_aw_size,
    input  logic [1:0]        s_aw_burst,
    input  logic              s_aw_lock,
    input  logic [3:0]        s_aw_cache,
    input  logic [2:0]        s_aw_prot,
    input  logic [3:0]        s_aw_qos,

    input  logic              s_w_valid,
    output logic              s_w_ready,
    input  logic [DATA_W-1:0] s_w_data,
    input  logic [STRB_W-1:0] s_w_strb,
    input  logic              s_w_last,

    output logic              s_b_valid,
    input  logic              s_b_ready,
    output logic [ID_W-1:0]   s_b_id,
    output logic [1:0]        s_b_resp,

    output logic              s_r_valid,
    input  logic              s_r_ready,
    output logic [ID_W-1:0]   s_r_id,
    output logic [DATA_W-1:0] s_r_data,
    output logic [1:0]        s_r_resp,
    output logic              s_r_last,

    output logic              m_ar_valid,
    input  logic              m_ar_ready,
    output logic [ADDR_W-1:0] m_ar_addr,
    output logic [ID_W-1:0]   m_ar_id,
    output logic [7:0]        m_ar_len,
    output logic [2:0]        m_ar_size,
    output logic [1:0]        m_ar_burst,
    output logic              m_ar_lock,
    output logic [3:0]        m_ar_cache,
    output logic [2:0]        m_ar_prot,
    output logic [3:0]        m_ar_qos,

    output logic              m_aw_valid,
    input  logic              m_aw_ready,
    output logic [ADDR_W-1:0] m_aw_addr,
    output logic [ID_W-1:0]   m_aw_id,
    output logic [7:0]        m_aw_len,
    output logic [2:0]        m_aw_size,
    output logic [1:0]        m_aw_burst,
    output logic              m_aw_lock,
    output logic [3:0]        m_aw_cache,
    output logic [2:0]        m_aw_prot,
    output logic [3:0]        m_aw_qos,

    output logic              m_w_valid,
    input  logic              m_w_ready,
    output logic [DATA_W-1:0] m_w_data,
    output logic [STRB_W-1:0] m_w_strb,
    output logic              m_w_last,

    input  logic              m_b_valid,
    output logic              m_b_ready,
    input  logic [ID_W-1:0]   m_b_id,
    input  logic [1:0]        m_b_resp,

    input  logic              m_r_valid,
    output logic              m_r_ready,
    input  logic [ID_W-1:0]   m_r_id,
    input  logic [DATA_W-1:0] m_r_data,
    input  logic [1:0]        m_r_resp,
    input  logic              m_r_last,

    output logic [15:0]       err_count
);

    ax_t  s_ar, m_ar, s_aw, m_aw;
    logic ar_legal, aw_legal;

    assign s_ar = '{addr: s_ar_addr, id: s_ar_id, len: s_ar_len, size: s_ar_size,
                    burst: s_ar_burst, lock: s_ar_lock, cache: s_ar_cache,
                    prot: s_ar_prot, qos: s_ar_qos};
    assign s_aw = '{addr: s_aw_addr, id: s_aw_id, len: s_aw_len, size: s_aw_size,
                    burst: s_aw_burst, lock: s_aw_lock, cache: s_aw_cache,
                    prot: s_aw_prot, qos: s_aw_qos};

    mem_axi_win_check u_ar_check (.s_ax(s_ar), .legal(ar_legal), .m_ax(m_ar));
    mem_axi_win_check u_aw_check (.s_ax(s_aw), .legal(aw_legal), .m_ax(m_aw));

    assign {m_ar_addr, m_ar_id, m_ar_len, m_ar_size, m_ar_burst,
            m_ar_lock, m_ar_cache, m_ar_prot, m_ar_qos} = m_ar;
    assign {m_aw_addr, m_aw_id, m_aw_len, m_aw_size, m_aw_burst,
            m_aw_lock, m_aw_cache, m_aw_prot, m_aw_qos} = m_aw;

    rd_state_t         rd_state_q, rd_state_d;
    wr_state_t         wr_state_q, wr_state_d;
    logic [CNT_W-1:0]  rd_out_q, rd_out_d;
    logic [CNT_W-1:0]  wr_out_q, wr_out_d;
    logic [CNT_W-1:0]  w_pend_q, w_pend_d;
    logic [ID_W-1:0]   rd_id_q, rd_id_d;
    logic [7:0]        rd_len_q, rd_len_d;
    logic [7:0]        rd_beat_q, rd_beat_d;
    logic [ID_W-1:0]   wr_id_q, wr_id_d;
    logic [15:0]       err_count_q, err_count_d;

    logic rd_idle, rd_room, rd_resp, r_last_beat, r_err_done, m_r_done;
    logic wr_idle, wr_room, wr_resp, w_drain, w_fwd, w_err_done;
    logic ar_err_acc, aw_err_acc, m_w_done;
    logic [16:0] err_sum;

    // Read address and data path
    always_comb begin
        rd_idle     = rd_state_q == R_IDLE;
        rd_resp     = rd_state_q == R_RESP;
        rd_room     = rd_out_q != CNT_W'(MAX_OUT);
        r_last_beat = rd_beat_q == rd_len_q;

        m_ar_valid = s_ar_valid && ar_legal && rd_idle && rd_room;
        s_ar_ready = s_ar_valid && rd_idle && (ar_legal ? (m_ar_ready && rd_room) : 1'b1);
        ar_err_acc = s_ar_valid && rd_idle && !ar_legal;

        s_r_valid = rd_resp ? 1'b1            : m_r_valid;
        s_r_id    = rd_resp ? rd_id_q         : m_r_id;
        s_r_data  = rd_resp ? '0              : m_r_data;
        s_r_resp  = rd_resp ? AXI_RESP_DECERR : m_r_resp;
        s_r_last  = rd_resp ? r_last_beat     : m_r_last;
        m_r_ready = !rd_resp && s_r_ready;

        m_r_done   = m_r_valid && m_r_ready && m_r_last;
        r_err_done = rd_resp && s_r_ready && r_last_beat;
        rd_out_d   = rd_out_q + CNT_W'(m_ar_valid && m_ar_ready) - CNT_W'(m_r_done);
    end

    always_comb begin
        rd_state_d = rd_state_q;
        rd_id_d    = rd_id_q;
        rd_len_d   = rd_len_q;
        rd_beat_d  = rd_beat_q;
        case (rd_state_q)
            R_IDLE: if (ar_err_acc) begin
                rd_state_d = R_WAIT;
                rd_id_d    = s_ar_id;
                rd_len_d   = s_ar_len;
                rd_beat_d  = '0;
            end
            // Older legal reads must finish before the error data may use s_r.
            R_WAIT: if (rd_out_q == '0) rd_state_d = R_RESP;
            R_RESP: if (s_r_ready) begin
                if (r_last_beat) rd_state_d = R_IDLE;
                else             rd_beat_d  = rd_beat_q + 8'd1;
            end
            default: rd_state_d = R_IDLE;
        endcase
    end

    // Write address, data and response path
    always_comb begin
        wr_idle = wr_state_q == W_IDLE;
        wr_resp = wr_state_q == W_RESP;
        w_drain = wr_state_q == W_DRAIN;
        wr_room = wr_out_q != CNT_W'(MAX_OUT);
        w_fwd   = w_pend_q != '0;

        m_aw_valid = s_aw_valid && aw_legal && wr_idle && wr_room;
        s_aw_ready = s_aw_valid && wr_idle && (aw_legal ? (m_aw_ready && wr_room) : 1'b1);
        aw_err_acc = s_aw_valid && wr_idle && !aw_legal;

        m_w_valid = !w_drain && w_fwd && s_w_valid;
        m_w_data  = s_w_data;
        m_w_strb  = s_w_strb;
        m_w_last  = s_w_last;
        s_w_ready = w_drain || (w_fwd && m_w_ready);
        m_w_done  = m_w_valid && m_w_ready && m_w_last;

        s_b_valid = wr_resp ? 1'b1            : m_b_valid;
        s_b_id    = wr_resp ? wr_id_q         : m_b_id;
        s_b_resp  = wr_resp ? AXI_RESP_DECERR : m_b_resp;
        m_b_ready = !wr_resp && s_b_ready;

        w_err_done = wr_resp && s_b_ready;
        wr_out_d   = wr_out_q + CNT_W'(m_aw_valid && m_aw_ready) - CNT_W'(m_b_valid && m_b_ready);
        w_pend_d   = w_pend_q + CNT_W'(m_aw_valid && m_aw_ready) - CNT_W'(m_w_done);
    end

    always_comb begin
        wr_state_d = wr_state_q;
        wr_id_d    = wr_id_q;
        case (wr_state_q)
            W_IDLE:  if (aw_err_acc) begin
                wr_state_d = W_WAIT;
                wr_id_d    = s_aw_id;
            end
            W_WAIT:  if (w_pend_q == '0 && wr_out_q == '0) wr_state_d = W_DRAIN;
            W_DRAIN: if (s_w_valid && s_w_last) wr_state_d = W_RESP;
            W_RESP:  if (s_b_ready) wr_state_d = W_IDLE;
            default: wr_state_d = W_IDLE;
        endcase
    end

    // A read and a write error can retire in the same cycle.
    always_comb begin
        err_sum     = {1'b0, err_count_q} + 17'(r_err_done) + 17'(w_err_done);
        err_count_d = err_sum[16] ? 16'hFFFF : err_sum[15:0];
    end

    assign err_count = err_count_q;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            rd_state_q  <= R_IDLE;
            wr_state_q  <= W_IDLE;
            rd_out_q    <= '0;
            wr_out_q    <= '0;
            w_pend_q    <= '0;
            rd_id_q     <= '0;
            rd_len_q    <= '0;
            rd_beat_q   <= '0;
            wr_id_q     <= '0;
            err_count_q <= '0;
        end else begin
            rd_state_q  <= rd_state_d;
            wr_state_q  <= wr_state_d;
            rd_out_q    <= rd_out_d;
            wr_out_q    <= wr_out_d;
            w_pend_q    <= w_pend_d;
            rd_id_q     <= rd_id_d;
            rd_len_q    <= rd_len_d;
            rd_beat_q   <= rd_beat_d;
            wr_id_q     <= wr_id_d;
            err_count_q <= err_count_d;
        end
    end

endmodule

// File: tb/tb_mem_axi_window.sv
// Bench for mem_axi_window: directed scenarios plus random bursts against a window/remap model.
module tb_mem_axi_window;
    import mem_axi_pkg::*;

    logic clock = 1'b0;
    logic reset_n;
    always #5 clock = ~clock;

    logic s_ar_valid, s_ar_ready, s_ar_lock, s_aw_valid, s_aw_ready, s_aw_lock;
    logic [31:0] s_ar_addr, s_aw_addr, m_ar_addr, m_aw_addr;
    logic [5:0]  s_ar_id, s_aw_id, m_ar_id, m_aw_id;
    logic [7:0]  s_ar_len, s_aw_len, m_ar_len, m_aw_len;
    logic [2:0]  s_ar_size, s_aw_size, m_ar_size, m_aw_size, s_ar_prot, s_aw_prot, m_ar_prot, m_aw_prot;
    logic [1:0]  s_ar_burst, s_aw_burst, m_ar_burst, m_aw_burst;
    logic [3:0]  s_ar_cache, s_aw_cache, m_ar_cache, m_aw_cache, s_ar_qos, s_aw_qos, m_ar_qos, m_aw_qos;
    logic m_ar_valid, m_ar_ready, m_ar_lock, m_aw_valid, m_aw_ready, m_aw_lock;
    logic s_w_valid, s_w_ready, s_w_last, m_w_valid, m_w_ready, m_w_last;
    logic [63:0] s_w_data, m_w_data, s_r_data, m_r_data;
    logic [7:0]  s_w_strb, m_w_strb;
    logic s_b_valid, s_b_ready, m_b_valid, m_b_ready;
    logic [5:0]  s_b_id, m_b_id, s_r_id, m_r_id;
    logic [1:0]  s_b_resp, m_b_resp, s_r_resp, m_r_resp;
    logic s_r_valid, s_r_ready, s_r_last, m_r_valid, m_r_ready, m_r_last;
    logic [15:0] err_count;

    mem_axi_window dut (
        .clock(clock), .reset_n(reset_n),
        .s_ar_valid(s_ar_valid), .s_ar_ready(s_ar_ready), .s_ar_addr(s_ar_addr), .s_ar_id(s_ar_id),
        .s_ar_len(s_ar_len), .s_ar_size(s_ar_size), .s_ar_burst(s_ar_burst), .s_ar_lock(s_ar_lock),
        .s_ar_cache(s_ar_cache), .s_ar_prot(s_ar_prot), .s_ar_qos(s_ar_qos),
        .s_aw_valid(s_aw_valid), .s_aw_ready(s_aw_ready), .s_aw_addr(s_aw_addr), .s_aw_id(s_aw_id),
        .s_aw_len(s_aw_len), .s_aw_size(s_aw_size), .s_aw_burst(s_aw_burst), .s_aw_lock(s_aw_lock),
        .s_aw_cache(s_aw_cache), .s_aw_prot(s_aw_prot), .s_aw_qos(s_aw_qos),
        .s_w_valid(s_w_valid), .s_w_ready(s_w_ready), .s_w_data(s_w_data), .s_w_strb(s_w_strb), .s_w_last(s_w_last),
        .s_b_valid(s_b_valid), .s_b_ready(s_b_ready), .s_b_id(s_b_id), .s_b_resp(s_b_resp),
        .s_r_valid(s_r_valid), .s_r_ready(s_r_ready), .s_r_id(s_r_id), .s_r_data(s_r_data),
        .s_r_resp(s_r_resp), .s_r_last(s_r_last),
        .m_ar_valid(m_ar_valid), .m_ar_ready(m_ar_ready), .m_ar_addr(m_ar_addr), .m_ar_id(m_ar_id),
        .m_ar_len(m_ar_len), .m_ar_size(m_ar_size), .m_ar_burst(m_ar_burst), .m_ar_lock(m_ar_lock),
        .m_ar_cache(m_ar_cache), .m_ar_prot(m_ar_prot), .m_ar_qos(m_ar_qos),
        .m_aw_valid(m_aw_valid), .m_aw_ready(m_aw_ready), .m_aw_addr(m_aw_addr), .m_aw_id(m_aw_id),
        .m_aw_len(m_aw_len), .m_aw_size(m_aw_size), .m_aw_burst(m_aw_burst), .m_aw_lock(m_aw_lock),
        .m_aw_cache(m_aw_cache), .m_aw_prot(m_aw_prot), .m_aw_qos(m_aw_qos),
        .m_w_valid(m_w_valid), .m_w_ready(m_w_ready), .m_w_data(m_w_data), .m_w_strb(m_w_strb), .m_w_last(m_w_last),
        .m_b_valid(m_b_valid), .m_b_ready(m_b_ready), .m_b_id(m_b_id), .m_b_resp(m_b_resp),
        .m_r_valid(m_r_valid), .m_r_ready(m_r_ready), .m_r_id(m_r_id), .m_r_data(m_r_data),
        .m_r_resp(m_r_resp), .m_r_last(m_r_last),
        .err_count(err_count)
    );

    int n_vec = 0;
    int n_err = 0;
    int exp_err = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference: tag 8, and the byte range touched stays inside the 256 MB window.
    function automatic bit model_legal(input logic [31:0] a, input logic [7:0] len,
                                       input logic [2:0] size, input logic [1:0] burst);
        longint unsigned ofs, bytes;
        ofs   = longint'(a % 32'h1000_0000);
        bytes = (burst == 2'd0) ? 1 : longint'(len) + 1;
        bytes = bytes * (longint'(1) << size);
        if (a / 32'h1000_0000 != 32'd8) return 1'b0;
        if (burst == 2'd2) return 1'b1;
        return (ofs + bytes) <= 64'h1000_0000;
    endfunction

    function automatic logic [31:0] remap(input logic [31:0] a);
        return (a % 32'h1000_0000) + 32'h1000_0000;
    endfunction

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic idle_inputs();
        s_ar_valid = 0; s_ar_addr = 0; s_ar_id = 0; s_ar_len = 0; s_ar_size = 0; s_ar_burst = 0;
        s_ar_lock = 0; s_ar_cache = 0; s_ar_prot = 0; s_ar_qos = 0;
        s_aw_valid = 0; s_aw_addr = 0; s_aw_id = 0; s_aw_len = 0; s_aw_size = 0; s_aw_burst = 0;
        s_aw_lock = 0; s_aw_cache = 0; s_aw_prot = 0; s_aw_qos = 0;
        s_w_valid = 0; s_w_data = 0; s_w_strb = 0; s_w_last = 0; s_b_ready = 0; s_r_ready = 0;
        m_ar_ready = 0; m_aw_ready = 0; m_w_ready = 0;
        m_b_valid = 0; m_b_id = 0; m_b_resp = 0;
        m_r_valid = 0; m_r_id = 0; m_r_data = 0; m_r_resp = 0; m_r_last = 0;
    endtask

    task automatic drive_ar(input logic [31:0] a, input logic [5:0] id, input logic [7:0] len,
                            input logic [2:0] size, input logic [1:0] burst);
        s_ar_addr = a; s_ar_id = id; s_ar_len = len; s_ar_size = size; s_ar_burst = burst;
        s_ar_lock = 1'($urandom); s_ar_cache = 4'($urandom); s_ar_prot = 3'($urandom); s_ar_qos = 4'($urandom);
        s_ar_valid = 1; m_ar_ready = 1;
    endtask

    task automatic send_ar(input logic [31:0] a, input logic [5:0] id, input logic [7:0] len,
                           input logic [2:0] size, input logic [1:0] burst, output logic legal);
        legal = model_legal(a, len, size, burst);
        drive_ar(a, id, len, size, burst);
        #1;
        chk("ar_ready", s_ar_ready, 1);
        chk("m_ar_valid", m_ar_valid, legal);
        if (legal) begin
            chk("m_ar_addr", m_ar_addr, remap(a));
            chk("m_ar_fields", {m_ar_id, m_ar_len, m_ar_size, m_ar_burst, m_ar_lock, m_ar_cache, m_ar_prot, m_ar_qos},
                {id, len, size, burst, s_ar_lock, s_ar_cache, s_ar_prot, s_ar_qos});
        end
        tick();
        s_ar_valid = 0; m_ar_ready = 0;
    endtask

    task automatic send_aw(input logic [31:0] a, input logic [5:0] id, input logic [7:0] len,
                           input logic [2:0] size, input logic [1:0] burst, output logic legal);
        legal = model_legal(a, len, size, burst);
        s_aw_addr = a; s_aw_id = id; s_aw_len = len; s_aw_size = size; s_aw_burst = burst;
        s_aw_lock = 1'($urandom); s_aw_cache = 4'($urandom); s_aw_prot = 3'($urandom); s_aw_qos = 4'($urandom);
        s_aw_valid = 1; m_aw_ready = 1;
        #1;
        chk("aw_ready", s_aw_ready, 1);
        chk("m_aw_valid", m_aw_valid, legal);
        if (legal) begin
            chk("m_aw_addr", m_aw_addr, remap(a));
            chk("m_aw_fields", {m_aw_id, m_aw_len, m_aw_size, m_aw_burst, m_aw_lock, m_aw_cache, m_aw_prot, m_aw_qos},
                {id, len, size, burst, s_aw_lock, s_aw_cache, s_aw_prot, s_aw_qos});
        end
        tick();
        s_aw_valid = 0; m_aw_ready = 0;
    endtask

    task automatic legal_r(input logic [5:0] id, input logic [7:0] len);
        logic [63:0] d;
        logic [1:0]  rs;
        for (int b = 0; b <= int'(len); b++) begin
            d = {$urandom, $urandom};
            rs = 2'($urandom_range(0, 1));
            m_r_valid = 1; m_r_id = id; m_r_data = d; m_r_resp = rs; m_r_last = (b == int'(len));
            s_r_ready = 1;
            #1;
            chk("r_pass", {s_r_valid, s_r_id, s_r_resp, s_r_last, m_r_ready}, {1'b1, id, rs, b == int'(len), 1'b1});
            chk("r_data", s_r_data, d);
            tick();
        end
        m_r_valid = 0; s_r_ready = 0;
    endtask

    task automatic err_r(input logic [5:0] id, input logic [7:0] len);
        for (int b = 0; b <= int'(len); b++) begin
            if ($urandom_range(0, 2) == 0) begin
                s_r_ready = 0;
                tick();
            end
            s_r_ready = 1;
            #1;
            for (int k = 0; k < 20 && !s_r_valid; k++) tick();
            chk("r_err_valid", s_r_valid, 1);
            chk("r_err_beat", {s_r_id, s_r_resp, s_r_last}, {id, 2'b11, b == int'(len)});
            chk("r_err_data", s_r_data, 0);
            tick();
        end
        s_r_ready = 0;
        exp_err++;
        chk("err_count_r", err_count, exp_err);
    endtask

    task automatic legal_w(input logic [7:0] len);
        logic [63:0] d;
        logic [7:0]  st;
        for (int b = 0; b <= int'(len); b++) begin
            d = {$urandom, $urandom};
            st = 8'($urandom);
            s_w_valid = 1; s_w_data = d; s_w_strb = st; s_w_last = (b == int'(len)); m_w_ready = 1;
            #1;
            chk("w_pass", {m_w_valid, s_w_ready, m_w_strb, m_w_last}, {1'b1, 1'b1, st, b == int'(len)});
            chk("w_data", m_w_data, d);
            tick();
        end
        s_w_valid = 0; s_w_last = 0; m_w_ready = 0;
    endtask

    task automatic drain_w(input logic [7:0] len);
        for (int b = 0; b <= int'(len); b++) begin
            s_w_valid = 1; s_w_data = {$urandom, $urandom}; s_w_strb = 8'hFF; s_w_last = (b == int'(len));
            m_w_ready = 1;
            #1;
            for (int k = 0; k < 20 && !s_w_ready; k++) tick();
            chk("w_drain_ready", s_w_ready, 1);
            chk("w_drain_blocked", m_w_valid, 0);
            tick();
        end
        s_w_valid = 0; s_w_last = 0; m_w_ready = 0;
    endtask

    task automatic legal_b(input logic [5:0] id);
        logic [1:0] rs;
        rs = 2'($urandom_range(0, 1));
        m_b_valid = 1; m_b_id = id; m_b_resp = rs; s_b_ready = 1;
        #1;
        chk("b_pass", {s_b_valid, s_b_id, s_b_resp, m_b_ready}, {1'b1, id, rs, 1'b1});
        tick();
        m_b_valid = 0; s_b_ready = 0;
    endtask

    task automatic err_b(input logic [5:0] id);
        s_b_ready = 1;
        #1;
        for (int k = 0; k < 20 && !s_b_valid; k++) tick();
        chk("b_err", {s_b_valid, s_b_id, s_b_resp}, {1'b1, id, 2'b11});
        tick();
        s_b_ready = 0;
        exp_err++;
        chk("err_count_w", err_count, exp_err);
    endtask

    function automatic logic [31:0] pick_addr();
        case ($urandom_range(0, 3))
            0, 1:    return {4'h8, 28'($urandom)};
            2:       return $urandom;
            default: return 32'h8FFF_FF00 + 32'($urandom_range(0, 255));
        endcase
    endfunction

    initial begin
        logic lg;
        logic [31:0] a;
        logic [5:0]  id;
        logic [7:0]  len;

        idle_inputs();
        reset_n = 0;
        tick(); tick();
        chk("reset_handshakes", {s_ar_ready, m_ar_valid, s_aw_ready, m_aw_valid, s_w_ready, m_w_valid,
                                 s_r_valid, s_b_valid, m_r_ready, m_b_ready}, 0);
        chk("reset_err_count", err_count, 0);
        reset_n = 1;
        tick();

        // Legal INCR read, then an out-of-window read.
        send_ar(32'h8000_1000, 6'd3, 8'd7, 3'd3, BURST_INCR, lg);
        chk("legal_rd_remap", m_ar_addr, 32'h1000_1000);
        legal_r(6'd3, 8'd7);
        send_ar(32'h4000_0000, 6'd5, 8'd3, 3'd3, BURST_INCR, lg);
        err_r(6'd5, 8'd3);

        // Write that would cross the top of the window.
        send_aw(32'h8FFF_FFC0, 6'd4, 8'd15, 3'd3, BURST_INCR, lg);
        drain_w(8'd15);
        err_b(6'd4);

        // Error write queued behind an outstanding legal write.
        send_aw(32'h8000_2000, 6'd7, 8'd3, 3'd3, BURST_INCR, lg);
        legal_w(8'd3);
        send_aw(32'h8FFF_FFC0, 6'd9, 8'd15, 3'd3, BURST_INCR, lg);
        s_w_valid = 1; s_w_last = 0; s_b_ready = 1;
        for (int c = 0; c < 4; c++) begin
            #1;
            chk("order_w_held", s_w_ready, 0);
            chk("order_b_held", s_b_valid, 0);
            tick();
        end
        legal_b(6'd7);
        drain_w(8'd15);
        err_b(6'd9);

        // Fill the read tracker, then a ninth AR must wait for a final beat.
        for (int i = 0; i < MAX_OUT; i++)
            send_ar(32'h8000_0000 + 32'(i * 64), 6'(i + 1), 8'd0, 3'd3, BURST_INCR, lg);
        drive_ar(32'h8000_4000, 6'd20, 8'd0, 3'd3, BURST_INCR);
        for (int c = 0; c < 3; c++) begin
            #1;
            chk("max_out_stall", {s_ar_ready, m_ar_valid}, 2'b00);
            tick();
        end
        m_r_valid = 1; m_r_id = 6'd1; m_r_last = 1; m_r_data = 64'h55; m_r_resp = 0; s_r_ready = 1;
        #1;
        chk("max_out_still_full", s_ar_ready, 0);
        tick();
        m_r_valid = 0; s_r_ready = 0;
        #1;
        chk("max_out_released", {s_ar_ready, m_ar_valid}, 2'b11);
        tick();
        s_ar_valid = 0; m_ar_ready = 0;
        for (int i = 2; i <= MAX_OUT; i++) legal_r(6'(i), 8'd0);
        legal_r(6'd20, 8'd0);

        // Reset in the middle of a DECERR read response.
        send_ar(32'h4000_0000, 6'd2, 8'd3, 3'd3, BURST_INCR, lg);
        s_r_ready = 1;
        #1;
        for (int k = 0; k < 20 && !s_r_valid; k++) tick();
        tick(); tick();
        chk("pre_reset_beat2", {s_r_valid, s_r_last}, 2'b10);
        reset_n = 0;
        #1;
        chk("reset_mid_r_valid", s_r_valid, 0);
        chk("reset_mid_err", err_count, 0);
        exp_err = 0;
        tick();
        reset_n = 1;
        s_r_ready = 0;
        tick();
        chk("post_reset_idle", s_r_valid, 0);
        send_ar(32'h8000_0100, 6'd11, 8'd1, 3'd3, BURST_INCR, lg);
        legal_r(6'd11, 8'd1);

        // Random bursts, one at a time, against the window model.
        for (int t = 0; t < 40; t++) begin
            a = pick_addr();
            id = 6'($urandom);
            len = 8'($urandom_range(0, 15));
            if ($urandom_range(0, 1) == 1) begin
                send_ar(a, id, len, 3'($urandom_range(0, 3)), 2'($urandom_range(0, 2)), lg);
                if (lg) legal_r(id, len);
                else    err_r(id, len);
            end else begin
                send_aw(a, id, len, 3'($urandom_range(0, 3)), 2'($urandom_range(0, 2)), lg);
                if (lg) begin
                    legal_w(len);
                    legal_b(id);
                end else begin
                    drain_w(len);
                    err_b(id);
                end
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
